// File: rtl/inta_sequencer.sv
// inta_sequencer: CPU-side interrupt acknowledge controller for an 8086-mode PIC.
// Synchronises the PIC's INT request, produces the two-pulse INTA sequence,
// captures the vector byte from data_bus during the second pulse, and hands
// it to the core over a valid/ack handshake.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   INT          in   interrupt request from PIC (asynchronous, active-high)
//   int_enable   in   CPU interrupt enable, honoured only while idle
//   data_bus     in   system data bus, sampled on the last low cycle of pulse 2
//   INTA         out  interrupt acknowledge, active-low, idle high
//   vector       out  captured interrupt vector
//   vector_valid out  vector holds an unconsumed value
//   vector_ack   in   core consumes the vector (honoured only while valid)
//   busy         out  sequencer is not idle
//   spurious     out  one-cycle pulse when INT drops before pulse 1 starts
module inta_sequencer #(
  parameter int unsigned PULSE_WIDTH = 4,
  parameter int unsigned GAP_WIDTH   = 2,
  parameter int unsigned HOLDOFF     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       INT,
  input  logic       int_enable,
  input  logic [7:0] data_bus,
  output logic       INTA,
  output logic [7:0] vector,
  output logic       vector_valid,
  input  logic       vector_ack,
  output logic       busy,
  output logic       spurious
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned VEC_W = 8;

  // Parameter legality: zero or values beyond the 8-bit counter are rejected.
  if ((PULSE_WIDTH == 0) || (PULSE_WIDTH > 255)) begin : g_bad_pulse_width
    $error("inta_sequencer: PULSE_WIDTH must be in 1..255");
  end
  if ((GAP_WIDTH == 0) || (GAP_WIDTH > 255)) begin : g_bad_gap_width
    $error("inta_sequencer: GAP_WIDTH must be in 1..255");
  end
  if ((HOLDOFF == 0) || (HOLDOFF > 255)) begin : g_bad_holdoff
    $error("inta_sequencer: HOLDOFF must be in 1..255");
  end

  // Counter reload values: a timed state lasts (load + 1) cycles.
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_WIDTH - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_WIDTH - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLDOFF - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_ACK1    = 3'd2,
    S_GAP     = 3'd3,
    S_ACK2    = 3'd4,
    S_VALID   = 3'd5,
    S_HOLDOFF = 3'd6
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [VEC_W-1:0]   vector_q, vector_d;
  logic               valid_q, valid_d;
  logic               inta_q, inta_d;
  logic               busy_q, busy_d;
  logic               spurious_q, spurious_d;
  logic               int_meta_q, int_s_q;

  // State, counter, synchroniser and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      vector_q   <= '0;
      valid_q    <= 1'b0;
      inta_q     <= 1'b1;
      busy_q     <= 1'b0;
      spurious_q <= 1'b0;
      int_meta_q <= 1'b0;
      int_s_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      vector_q   <= vector_d;
      valid_q    <= valid_d;
      inta_q     <= inta_d;
      busy_q     <= busy_d;
      spurious_q <= spurious_d;
      int_meta_q <= INT;
      int_s_q    <= int_meta_q;
    end
  end

  // Next-state, counter and output decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    vector_d   = vector_q;
    valid_d    = valid_q;
    spurious_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (int_s_q && int_enable) begin
          state_d = S_ARM;
        end
      end
      // Second look at the request; a withdrawn INT is reported, not acked.
      S_ARM: begin
        if (int_s_q) begin
          state_d = S_ACK1;
          cnt_d   = PULSE_LD;
        end else begin
          state_d    = S_IDLE;
          spurious_d = 1'b1;
        end
      end
      S_ACK1: begin
        if (cnt_q == '0) begin
          state_d = S_GAP;
          cnt_d   = GAP_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          state_d = S_ACK2;
          cnt_d   = PULSE_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      // The PIC's vector is taken on the final low cycle of pulse 2.
      S_ACK2: begin
        if (cnt_q == '0) begin
          state_d  = S_VALID;
          vector_d = data_bus;
          valid_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_VALID: begin
        if (vector_ack) begin
          state_d = S_HOLDOFF;
          valid_d = 1'b0;
          cnt_d   = HOLD_LD;
        end
      end
      // INT is deliberately not looked at while the PIC settles.
      S_HOLDOFF: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs follow the state being entered so they are flop-driven.
    inta_d = !((state_d == S_ACK1) || (state_d == S_ACK2));
    busy_d = (state_d != S_IDLE);
  end

  assign INTA         = inta_q;
  assign vector       = vector_q;
  assign vector_valid = valid_q;
  assign busy         = busy_q;
  assign spurious     = spurious_q;

endmodule

// File: tb/tb_inta_sequencer.sv
// Testbench for inta_sequencer: two instances (default timing and 1/1/1 timing),
// directed plus randomized steps, expected waveforms derived from edge arithmetic.
module tb_inta_sequencer;

  localparam int unsigned P0_PW = 4;
  localparam int unsigned P0_GW = 2;
  localparam int unsigned P0_HO = 4;
  localparam int unsigned P1_PW = 1;
  localparam int unsigned P1_GW = 1;
  localparam int unsigned P1_HO = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst_r;
  logic [1:0] int_r;
  logic [1:0] en_r;
  logic [1:0] ack_r;
  logic [7:0] db_r [2];
  wire  [1:0] inta_w;
  wire  [1:0] vv_w;
  wire  [1:0] busy_w;
  wire  [1:0] sp_w;
  wire  [7:0] vec0_w;
  wire  [7:0] vec1_w;

  int unsigned pw [2];
  int unsigned gw [2];
  int unsigned ho [2];
  int n_checks = 0;
  int n_errors = 0;

  inta_sequencer #(.PULSE_WIDTH(P0_PW), .GAP_WIDTH(P0_GW), .HOLDOFF(P0_HO)) u_dut0 (
    .clk(clk), .reset(rst_r[0]), .INT(int_r[0]), .int_enable(en_r[0]),
    .data_bus(db_r[0]), .INTA(inta_w[0]), .vector(vec0_w), .vector_valid(vv_w[0]),
    .vector_ack(ack_r[0]), .busy(busy_w[0]), .spurious(sp_w[0])
  );

  inta_sequencer #(.PULSE_WIDTH(P1_PW), .GAP_WIDTH(P1_GW), .HOLDOFF(P1_HO)) u_dut1 (
    .clk(clk), .reset(rst_r[1]), .INT(int_r[1]), .int_enable(en_r[1]),
    .data_bus(db_r[1]), .INTA(inta_w[1]), .vector(vec1_w), .vector_valid(vv_w[1]),
    .vector_ack(ack_r[1]), .busy(busy_w[1]), .spurious(sp_w[1])
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [7:0] vec_of(input int d);
    return (d == 1) ? vec1_w : vec0_w;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input int d, input string tag, input logic e_inta,
                           input logic e_valid, input logic e_busy, input logic e_sp);
    chk($sformatf("d%0d %s INTA", d, tag), 8'(inta_w[d]), 8'(e_inta));
    chk($sformatf("d%0d %s vector_valid", d, tag), 8'(vv_w[d]), 8'(e_valid));
    chk($sformatf("d%0d %s busy", d, tag), 8'(busy_w[d]), 8'(e_busy));
    chk($sformatf("d%0d %s spurious", d, tag), 8'(sp_w[d]), 8'(e_sp));
  endtask

  task automatic idle(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      cyc();
      chk_state(d, $sformatf("idle%0d", i), 1'b1, 1'b0, 1'b0, 1'b0);
    end
  endtask

  // One acknowledge transaction. k counts clock edges from the call; lat is the
  // edge at which INTA should first fall (4 from a fresh INT rise, 2 when INT_s
  // is already high in IDLE). Pulse 1 occupies [lat, lat+PW), the gap follows for
  // GW edges, pulse 2 for PW edges, and vector_valid appears with INTA's rise.
  task automatic run_seq(input int d, input logic [7:0] v, input int lat, input int ack_dly,
                         input bit hold_int, input bit ack_early, input bit drop_en,
                         input int rst_k, input bit toggle_ho);
    int p, g, h, a1, g1, a2, kv;
    p  = int'(pw[d]);
    g  = int'(gw[d]);
    h  = int'(ho[d]);
    a1 = lat;
    g1 = a1 + p;
    a2 = g1 + g;
    kv = a2 + p;
    int_r[d] = 1'b1;
    for (int k = 1; k <= kv; k++) begin
      db_r[d]  = (k > a2) ? v : ~v;
      ack_r[d] = ack_early && (k > a1) && (k <= g1);
      en_r[d]  = !(drop_en && (k > g1));
      rst_r[d] = (k == rst_k);
      cyc();
      if (k == rst_k) begin
        rst_r[d] = 1'b0;
        int_r[d] = 1'b0;
        en_r[d]  = 1'b1;
        ack_r[d] = 1'b0;
        chk_state(d, "after reset", 1'b1, 1'b0, 1'b0, 1'b0);
        chk($sformatf("d%0d after reset vector", d), vec_of(d), 8'h00);
        return;
      end
      chk_state(d, $sformatf("seq k%0d", k),
                !(((k >= a1) && (k < g1)) || ((k >= a2) && (k < kv))),
                (k == kv), (k >= lat - 1), 1'b0);
    end
    chk($sformatf("d%0d captured vector", d), vec_of(d), v);
    ack_r[d] = 1'b0;
    en_r[d]  = 1'b1;
    db_r[d]  = ~v;
    if (!hold_int) int_r[d] = 1'b0;
    for (int j = 0; j < ack_dly; j++) begin
      cyc();
      chk_state(d, $sformatf("wait%0d", j), 1'b1, 1'b1, 1'b1, 1'b0);
      chk($sformatf("d%0d wait%0d vector", d, j), vec_of(d), v);
    end
    ack_r[d] = 1'b1;
    cyc();
    ack_r[d] = 1'b0;
    chk_state(d, "ack", 1'b1, 1'b0, 1'b1, 1'b0);
    chk($sformatf("d%0d vector after ack", d), vec_of(d), v);
    // INT may wiggle early in holdoff; it is low again before IDLE can sample it.
    for (int j = 1; j <= h; j++) begin
      if (toggle_ho) int_r[d] = (j <= 2) ? 1'($urandom % 2) : 1'b0;
      cyc();
      chk_state(d, $sformatf("hold%0d", j), 1'b1, 1'b0, (j < h), 1'b0);
    end
  endtask

  // A one-cycle INT gives a one-cycle INT_s: ARM is entered and finds it gone.
  task automatic spur(input int d);
    for (int k = 1; k <= 8; k++) begin
      int_r[d] = (k == 1);
      cyc();
      chk_state(d, $sformatf("spur k%0d", k), 1'b1, 1'b0, (k == 3), (k == 4));
    end
  endtask

  initial begin
    logic [7:0] v;
    pw[0] = P0_PW; gw[0] = P0_GW; ho[0] = P0_HO;
    pw[1] = P1_PW; gw[1] = P1_GW; ho[1] = P1_HO;
    rst_r = 2'b11;
    int_r = 2'b00;
    en_r  = 2'b11;
    ack_r = 2'b00;
    db_r[0] = 8'h00;
    db_r[1] = 8'h00;

    // Reset state
    repeat (3) cyc();
    for (int d = 0; d < 2; d++) begin
      chk_state(d, "reset", 1'b1, 1'b0, 1'b0, 1'b0);
      chk($sformatf("d%0d reset vector", d), vec_of(d), 8'h00);
    end
    rst_r = 2'b00;
    idle(0, 3);

    // Basic capture, ack one cycle after valid
    run_seq(0, 8'h4B, 4, 1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    idle(0, 2);

    // Spurious requests with random spacing
    for (int i = 0; i < 3; i++) begin
      spur(0);
      idle(0, int'($urandom_range(0, 4)));
    end

    // Masked request, then enable, then drop enable during the gap
    en_r[0]  = 1'b0;
    int_r[0] = 1'b1;
    idle(0, 50);
    run_seq(0, 8'hC3, 2, 2, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    idle(0, 3);

    // Ack during pulse 1 is ignored; INT toggles during holdoff
    run_seq(0, 8'h96, 4, 0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    run_seq(0, 8'h3C, 4, 3, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    idle(0, 3);

    // Reset in the second cycle of pulse 2 (pulse 2 starts at edge 10)
    run_seq(0, 8'h5A, 4, 0, 1'b0, 1'b0, 1'b0, 12, 1'b0);
    idle(0, 20);

    // Randomized transactions
    for (int i = 0; i < 5; i++) begin
      v = 8'($urandom);
      run_seq(0, v, 4, int'($urandom_range(0, 5)), 1'b0, 1'($urandom % 2),
              1'($urandom % 2), 0, 1'($urandom % 2));
      idle(0, int'($urandom_range(1, 4)));
    end

    // Back-to-back on the minimal-timing instance with INT held high
    idle(1, 2);
    run_seq(1, 8'h20, 4, 10, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    run_seq(1, 8'h21, 2, 10, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    idle(1, 5);
    spur(1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
